stopwatch_top: RTL and testbench
================================

// Module: stopwatch_top
// PURPOSE
//   Minutes:seconds stopwatch with start, stop (pause) and clear controls.
//   It has a 3-state control FSM and a prescaled mm:ss counter, and is the top of the stopwatch design.
//   Its outputs drive the display and status logic directly.
// PARAMETERS
//   TICKS_PER_SEC  1   clk cycles per counted second. 1 gives one second per clock, for simulation.
//   MAX_MIN        99  highest minutes value; the count wraps to 00:00 after MAX_MIN:59.
// PORTS
//   clk      in   1  single system clock, rising edge
//   rst_n    in   1  reset, asynchronous and active-low
//   start    in   1  start/resume request, sampled on clk, level-sensitive
//   stop     in   1  pause request, sampled on clk
//   reset    in   1  synchronous clear request (user control, not the system reset)
//   minutes  out  8  elapsed minutes, binary, range 0..MAX_MIN
//   seconds  out  6  elapsed seconds, binary, range 0..59
//   status   out  2  FSM state: 00=IDLE, 01=RUNNING, 10=PAUSED; 11 never driven
// BEHAVIOUR
//   - Outputs while rst_n=0, applied immediately: status=IDLE, minutes=0, seconds=0, prescaler=0.
//   - All other state changes happen only on rising clk. Every output is a register.
//   - Control priority in one cycle: reset > stop > start.
//   - FSM transitions:
//       any state + reset=1                     -> IDLE; minutes=0, seconds=0, prescaler=0
//       IDLE or PAUSED + start=1                -> RUNNING
//       RUNNING + stop=1                        -> PAUSED; count frozen
//       start while RUNNING                     -> ignored
//       stop while IDLE or PAUSED               -> ignored
//       start and stop high together            -> stop wins: RUNNING->PAUSED, otherwise no change
//   - Latency: status changes on the clk edge that samples the request.
//   - Counting: a tick occurs on an edge where the registered status is RUNNING and prescaler==TICKS_PER_SEC-1.
//     On that same edge the prescaler returns to 0. Otherwise, while RUNNING, the prescaler increments.
//     With TICKS_PER_SEC=1, seconds advances on every edge where status was already RUNNING.
//     The edge that samples start therefore does not count.
//   - On a tick:
//       seconds<59                          -> seconds+1
//       seconds==59, minutes<MAX_MIN        -> seconds=0, minutes+1
//       seconds==59, minutes==MAX_MIN       -> 00:00, status stays RUNNING
//   - PAUSED holds minutes, seconds and prescaler. Resuming continues from the held values, with no reset of the prescaler.
//   - IDLE holds 00:00.
//   - The pausing edge (stop sampled while RUNNING) does not count.
//   - The clearing edge (reset sampled) wins over any tick on that edge.
//   - rst_n asserted mid-count immediately forces the reset values above.
// STRUCTURE
//   - Shared package stopwatch_pkg:
//       state encoding constants S_IDLE=2'b00, S_RUN=2'b01, S_PAUSE=2'b10
//       SEC_MAX=59
//   - Sub-module stopwatch_counter:
//       inputs: clk, rst_n, clear, en
//       contains the prescaler and the mm:ss counters with wrap logic
//       outputs: minutes, seconds
//   - The top-level FSM in stopwatch_top drives en=(state==S_RUN) and clear=reset.
// TESTING
//   1. Hold rst_n=0 for 20 ns, then release.
//      -> status=00, time 00:00, stable with no inputs.
//   2. Pulse start for 1 cycle, then wait 65 cycles.
//      -> status=01; display reads 01:05 (±1 per sampling edge); seconds wraps 59->0 and minutes goes 0->1.
//   3. Pulse stop for 1 cycle, then wait 10 cycles.
//      -> status=10; time frozen at its value when paused.
//   4. Pulse start again, then wait 40 cycles.
//      -> status=01; counting resumes from the frozen value.
//   5. Pulse reset for 1 cycle.
//      -> next cycle status=00, time 00:00; then held for 5 cycles.
//   6. Boundary and priority cases:
//      - Preload 99:59 while running -> next tick gives 00:00, status still 01.
//      - start+stop in the same cycle while RUNNING -> PAUSED.
//      - rst_n pulsed low mid-count -> outputs clear before the next clk edge.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// Shared definitions for the mm:ss stopwatch: control state encoding and field limits.
package stopwatch_pkg;

  localparam int unsigned MIN_W   = 8;
  localparam int unsigned SEC_W   = 6;
  localparam int unsigned STATE_W = 2;
  localparam int unsigned SEC_MAX = 59;

  // Encoding is visible on the status port; 2'b11 is never produced.
  typedef enum logic [STATE_W-1:0] {
    S_IDLE  = 2'b00,
    S_RUN   = 2'b01,
    S_PAUSE = 2'b10
  } state_t;

endpackage

// File: rtl/stopwatch_counter.sv
// Prescaled minutes:seconds counter with synchronous clear and wrap after MAX_MIN:59.
// Ports:
//   clk, rst_n : clock and asynchronous active-low reset
//   clear      : synchronous clear to 00:00 (wins over counting)
//   en         : advance the prescaler; a tick occurs when it reaches TICKS_PER_SEC-1
//   minutes    : elapsed minutes, 0..MAX_MIN (registered)
//   seconds    : elapsed seconds, 0..59 (registered)
module stopwatch_counter
  import stopwatch_pkg::*;
#(
  parameter int unsigned TICKS_PER_SEC = 1,
  parameter int unsigned MAX_MIN       = 99
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             en,
  output logic [MIN_W-1:0] minutes,
  output logic [SEC_W-1:0] seconds
);

  localparam int unsigned PRE_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;

  logic [PRE_W-1:0] r_presc;
  logic [MIN_W-1:0] r_min;
  logic [SEC_W-1:0] r_sec;
  logic             w_tick;

  assign w_tick  = en && (r_presc == PRE_W'(TICKS_PER_SEC - 1));
  assign minutes = r_min;
  assign seconds = r_sec;

  // Prescaler: free-runs only while enabled, holds otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_presc <= '0;
    end else if (clear) begin
      r_presc <= '0;
    end else if (w_tick) begin
      r_presc <= '0;
    end else if (en) begin
      r_presc <= r_presc + PRE_W'(1);
    end
  end

  // mm:ss counters; the full-scale tick returns to 00:00.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_min <= '0;
      r_sec <= '0;
    end else if (clear) begin
      r_min <= '0;
      r_sec <= '0;
    end else if (w_tick) begin
      if (r_sec != SEC_W'(SEC_MAX)) begin
        r_sec <= r_sec + SEC_W'(1);
      end else begin
        r_sec <= '0;
        if (r_min != MIN_W'(MAX_MIN)) begin
          r_min <= r_min + MIN_W'(1);
        end else begin
          r_min <= '0;
        end
      end
    end
  end

endmodule

// File: rtl/stopwatch_top.sv
// Stopwatch top: IDLE/RUNNING/PAUSED control FSM driving a prescaled mm:ss counter.
// Ports:
//   clk, rst_n : clock and asynchronous active-low reset
//   start      : start/resume request (level)
//   stop       : pause request
//   reset      : synchronous clear to IDLE and 00:00 (highest priority)
//   minutes    : elapsed minutes (registered)
//   seconds    : elapsed seconds (registered)
//   status     : 00=IDLE, 01=RUNNING, 10=PAUSED (registered)
module stopwatch_top
  import stopwatch_pkg::*;
#(
  parameter int unsigned TICKS_PER_SEC = 1,
  parameter int unsigned MAX_MIN       = 99
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stop,
  input  logic               reset,
  output logic [MIN_W-1:0]   minutes,
  output logic [SEC_W-1:0]   seconds,
  output logic [STATE_W-1:0] status
);

  state_t r_state;
  state_t w_state_next;
  logic   w_en;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next state: reset > stop > start.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE, S_PAUSE: if (start && !stop) w_state_next = S_RUN;
      S_RUN:           if (stop)           w_state_next = S_PAUSE;
      default:                             w_state_next = S_IDLE;
    endcase
    if (reset) w_state_next = S_IDLE;
  end

  // Count only on edges that start and end in RUNNING, so the starting and pausing edges are idle.
  assign w_en   = (r_state == S_RUN) && (w_state_next == S_RUN);
  assign status = r_state;

  stopwatch_counter #(
    .TICKS_PER_SEC (TICKS_PER_SEC),
    .MAX_MIN       (MAX_MIN)
  ) u_counter (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (reset),
    .en      (w_en),
    .minutes (minutes),
    .seconds (seconds)
  );

endmodule

// File: tb/tb_stopwatch_top.sv
// Self-checking bench for stopwatch_top: directed scenarios plus random control traffic
// compared against an elapsed-seconds reference model.
module tb_stopwatch_top;

  localparam int unsigned MAX_MIN = 99;
  localparam int          T_WRAP  = (MAX_MIN + 1) * 60;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       stop;
  logic       reset;
  logic [7:0] minutes;
  logic [5:0] seconds;
  logic [1:0] status;

  int n_checks;
  int n_errors;

  // Reference: mode 0=idle 1=running 2=paused; elapsed time as one seconds total.
  int m_mode;
  int m_t;

  stopwatch_top #(
    .TICKS_PER_SEC (1),
    .MAX_MIN       (MAX_MIN)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .stop    (stop),
    .reset   (reset),
    .minutes (minutes),
    .seconds (seconds),
    .status  (status)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, ".status"},  32'(status),  32'(m_mode));
    check({tag, ".minutes"}, 32'(minutes), 32'(m_t / 60));
    check({tag, ".seconds"}, 32'(seconds), 32'(m_t % 60));
  endtask

  // Apply one cycle of controls, advance the reference on the edge, then compare.
  task automatic step(input logic st, input logic sp, input logic rs, input string tag);
    @(negedge clk);
    start = st;
    stop  = sp;
    reset = rs;
    @(posedge clk);
    if (rs) begin
      m_mode = 0;
      m_t    = 0;
    end else if (m_mode == 1) begin
      if (sp) m_mode = 2;
      else    m_t    = (m_t + 1) % T_WRAP;
    end else if (st && !sp) begin
      m_mode = 1;
    end
    #1;
    check_model(tag);
  endtask

  task automatic idle_steps(input int n, input string tag);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, tag);
  endtask

  initial begin
    int frozen;
    n_checks = 0;
    n_errors = 0;
    m_mode   = 0;
    m_t      = 0;
    start    = 1'b0;
    stop     = 1'b0;
    reset    = 1'b0;

    // 1. Power-on reset.
    rst_n = 1'b0;
    #20;
    check("por.status",  32'(status),  32'd0);
    check("por.minutes", 32'(minutes), 32'd0);
    check("por.seconds", 32'(seconds), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    idle_steps(3, "idle");
    step(1'b0, 1'b1, 1'b0, "stop_in_idle");

    // 2. Start, run 65 seconds.
    step(1'b1, 1'b0, 1'b0, "start");
    check("start_no_count", 32'(seconds), 32'd0);
    idle_steps(65, "run");
    check("run65.min", 32'(minutes), 32'd1);
    check("run65.sec", 32'(seconds), 32'd5);
    step(1'b1, 1'b0, 1'b0, "start_while_run");

    // 3. Pause and hold.
    step(1'b0, 1'b1, 1'b0, "pause");
    frozen = 32'(minutes) * 60 + 32'(seconds);
    check("pause.status", 32'(status), 32'd2);
    idle_steps(10, "paused");
    check("paused.frozen", 32'(minutes) * 60 + 32'(seconds), 32'(frozen));

    // 4. Resume.
    step(1'b1, 1'b0, 1'b0, "resume");
    idle_steps(40, "resumed");
    check("resumed.total", 32'(minutes) * 60 + 32'(seconds), 32'(frozen + 40));

    // 5. Clear, even with start and stop asserted.
    step(1'b1, 1'b1, 1'b1, "clear");
    check("clear.status", 32'(status), 32'd0);
    idle_steps(5, "cleared");

    // 6a. Full-scale wrap from 99:59 to 00:00 while still running.
    step(1'b1, 1'b0, 1'b0, "wrap_start");
    idle_steps(T_WRAP - 1, "to_max");
    check("max.min", 32'(minutes), 32'(MAX_MIN));
    check("max.sec", 32'(seconds), 32'd59);
    step(1'b0, 1'b0, 1'b0, "wrap");
    check("wrap.min",    32'(minutes), 32'd0);
    check("wrap.sec",    32'(seconds), 32'd0);
    check("wrap.status", 32'(status),  32'd1);
    idle_steps(3, "after_wrap");

    // 6b. start+stop together while running pauses.
    step(1'b1, 1'b1, 1'b0, "start_stop_run");
    check("start_stop.status", 32'(status), 32'd2);
    step(1'b1, 1'b1, 1'b0, "start_stop_paused");
    check("start_stop_p.status", 32'(status), 32'd2);

    // Random control traffic.
    for (int i = 0; i < 3000; i++) begin
      step(1'(($urandom % 100) < 12), 1'(($urandom % 100) < 8),
           1'(($urandom % 100) < 2), "rand");
    end

    // 6c. Asynchronous reset mid-count.
    step(1'b1, 1'b0, 1'b0, "arst_start");
    idle_steps(7, "arst_run");
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst.status",  32'(status),  32'd0);
    check("arst.minutes", 32'(minutes), 32'd0);
    check("arst.seconds", 32'(seconds), 32'd0);
    m_mode = 0;
    m_t    = 0;
    @(posedge clk);
    #1;
    check_model("arst_hold");
    @(negedge clk);
    rst_n = 1'b1;
    idle_steps(2, "post_arst");
    step(1'b1, 1'b0, 1'b0, "post_arst_start");
    idle_steps(4, "post_arst_run");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
